tone_sequencer: RTL

TONE_SEQUENCER -- requirements
Module: tone_sequencer

---
 rtl/tone_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/tone_sequencer.sv
// tone_sequencer: queues {period, duration} notes and plays them back one
// after another into a tone generator, with tick-based note timing.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; tone silenced
// LOAD  | one cycle: pop the head note and latch its period/duration
// PLAY  | tone held; tick counter wraps every TICK_CYCLES, each wrap
//       | decrements the remaining duration until the note ends
module tone_sequencer #(
    parameter int CPU_CLOCK_FREQ = 50_000_000,
    parameter int TICK_CYCLES    = CPU_CLOCK_FREQ / 1000,
    parameter int DEPTH          = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     note_valid,
    input  logic [23:0]              note_period,
    input  logic [15:0]              note_duration,
    output logic                     note_ready,
    input  logic                     start,
    input  logic                     stop,
    output logic                     busy,
    output logic                     tone_enable,
    output logic [23:0]              tone_switch_period,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     done_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [39:0]     mem_q [DEPTH];
    logic [39:0]     mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [15:0]     remain_q, remain_d;
    logic            tone_en_q, tone_en_d;
    logic [23:0]     tone_per_q, tone_per_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            push;
    logic            pop;
    logic [39:0]     head;
    logic [23:0]     head_period;
    logic [15:0]     head_dur;

    assign note_ready         = (count_q < CW'(DEPTH));
    assign queue_count        = count_q;
    assign busy               = busy_q;
    assign tone_enable        = tone_en_q;
    assign tone_switch_period = tone_per_q;
    assign done_pulse         = done_q;

    assign head        = mem_q[rd_ptr_q];
    assign head_period = head[39:16];
    assign head_dur    = head[15:0];

    // Sequencing FSM: next state, note timing and registered tone outputs.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        remain_d   = remain_q;
        tone_en_d  = tone_en_q;
        tone_per_d = tone_per_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && (count_q != '0)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pop    = 1'b1;
                tick_d = '0;
                if (head_dur == 16'd0) begin
                    // zero-length note is dropped without ever sounding
                    tone_en_d  = 1'b0;
                    tone_per_d = '0;
                    remain_d   = '0;
                    if (count_q > CW'(1)) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tone_per_d = head_period;
                    tone_en_d  = (head_period != 24'd0);
                    remain_d   = head_dur;
                    state_d    = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (remain_q != 16'd0) begin
                        remain_d = remain_q - 16'd1;
                    end
                    if (remain_q <= 16'd1) begin
                        if (count_q != '0) begin
                            state_d = S_LOAD;
                        end else begin
                            state_d    = S_IDLE;
                            done_d     = 1'b1;
                            tone_en_d  = 1'b0;
                            tone_per_d = '0;
                        end
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (stop) begin
            state_d    = S_IDLE;
            tick_d     = '0;
            remain_d   = '0;
            tone_en_d  = 1'b0;
            tone_per_d = '0;
            done_d     = 1'b0;
            pop        = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    // Note FIFO: pointer/count update and entry write; stop flushes it.
    always_comb begin
        push     = note_valid && note_ready && !stop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = {note_period, note_duration};
        end
        if (stop) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tick_q     <= '0;
            remain_q   <= '0;
            tone_en_q  <= 1'b0;
            tone_per_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tick_q     <= tick_d;
            remain_q   <= remain_d;
            tone_en_q  <= tone_en_d;
            tone_per_q <= tone_per_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
